// File: rtl/hazard_scoreboard.sv
// Hazard and scoreboard control for the 5-stage RV32 pipeline.
// Produces operand forwarding selects and stage stall/flush controls. It tracks
// destination registers of in-flight long-latency (MDU) ops with a per-register
// busy scoreboard and an outstanding-op counter, and runs a memory-wait watchdog.
// Stall, flush and forward outputs are combinational; scoreboard, counter and
// watchdog outputs are registered.
module hazard_scoreboard #(
   parameter int unsigned NREGS       = 32,
   parameter int unsigned RAW         = $clog2(NREGS),
   parameter int unsigned LONG_MAX    = 2,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [RAW-1:0]   rs1D_addr_i,
   input  logic [RAW-1:0]   rs2D_addr_i,
   input  logic [RAW-1:0]   rdD_addr_i,
   input  logic             rdD_wr_ena_i,
   input  logic             long_opD_i,
   input  logic [RAW-1:0]   rs1E_addr_i,
   input  logic [RAW-1:0]   rs2E_addr_i,
   input  logic [RAW-1:0]   rdE_addr_i,
   input  logic             is_loadE_i,
   input  logic             is_memE_i,
   input  logic             long_issueE_i,
   input  logic [RAW-1:0]   rdM_addr_i,
   input  logic [RAW-1:0]   rdW_addr_i,
   input  logic             rdM_wr_ena_i,
   input  logic             rdW_wr_ena_i,
   input  logic             long_done_i,
   input  logic [RAW-1:0]   long_rd_i,
   input  logic             mem_done_i,
   input  logic             wrong_branch_i,
   output logic [1:0]       forwardAE_o,
   output logic [1:0]       forwardBE_o,
   output logic             stallF_o,
   output logic             stallD_o,
   output logic             stallE_o,
   output logic             stallM_o,
   output logic             stallW_o,
   output logic             flushD_o,
   output logic             flushE_o,
   output logic [NREGS-1:0] busy_o,
   output logic [2:0]       outstanding_o,
   output logic             mem_timeout_o,
   output logic             err_o
);

   localparam int unsigned CW = 3;
   localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(LONG_MAX);
   localparam logic [WW-1:0] WD_LIMIT = WW'(MEM_TIMEOUT);

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_W    = 2'b01;
   localparam logic [1:0] FWD_M    = 2'b10;

   // Registered state
   logic [NREGS-1:0] busy_q, busy_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WW-1:0]    wdog_q, wdog_d;
   logic             tmo_q, tmo_d;
   logic             err_q, err_d;

   // Hazard terms
   logic             mem_stall;
   logic             lw_stall;
   logic             sb_stall;
   logic             raw_hazard;
   logic             waw_hazard;
   logic             struct_hazard;
   logic             issue_acc;
   logic             done_eff;
   logic [NREGS-1:0] issue_mask;
   logic [NREGS-1:0] done_mask;
   logic [NREGS-1:0] eff_busy;
   logic [CW:0]      pending_long;

   // Forward select for one execute operand; M is younger so it wins over W
   function automatic logic [1:0] fwd_sel(
      input logic [RAW-1:0] rs,
      input logic [RAW-1:0] rd_m,
      input logic           we_m,
      input logic [RAW-1:0] rd_w,
      input logic           we_w
   );
      logic [1:0] sel;
      sel = FWD_NONE;
      if (rs != '0) begin
         if (we_m && (rd_m == rs)) begin
            sel = FWD_M;
         end else if (we_w && (rd_w == rs)) begin
            sel = FWD_W;
         end
      end
      return sel;
   endfunction

   // Operand forwarding muxes
   always_comb begin
      forwardAE_o = fwd_sel(rs1E_addr_i, rdM_addr_i, rdM_wr_ena_i, rdW_addr_i, rdW_wr_ena_i);
      forwardBE_o = fwd_sel(rs2E_addr_i, rdM_addr_i, rdM_wr_ena_i, rdW_addr_i, rdW_wr_ena_i);
   end

   // One-hot views of the issuing and completing long-op destinations
   always_comb begin
      issue_mask = '0;
      done_mask  = '0;
      if (long_issueE_i && (rdE_addr_i != '0)) begin
         issue_mask[rdE_addr_i] = 1'b1;
      end
      if (long_done_i) begin
         done_mask[long_rd_i] = 1'b1;
      end
   end

   // Effective busy: committed busy plus an op dispatching now, minus one retiring now.
   // The dispatching op is counted regardless of stallE to keep this free of loops.
   always_comb begin
      eff_busy    = (busy_q | issue_mask) & ~done_mask;
      eff_busy[0] = 1'b0;
   end

   // Hazard detection terms
   always_comb begin
      mem_stall     = is_memE_i & ~mem_done_i;
      lw_stall      = is_loadE_i & (rdE_addr_i != '0) &
                      ((rdE_addr_i == rs1D_addr_i) | (rdE_addr_i == rs2D_addr_i));
      raw_hazard    = eff_busy[rs1D_addr_i] | eff_busy[rs2D_addr_i];
      waw_hazard    = rdD_wr_ena_i & eff_busy[rdD_addr_i];
      pending_long  = {1'b0, count_q} + {{CW{1'b0}}, long_issueE_i};
      struct_hazard = long_opD_i & (pending_long >= {1'b0, CNT_MAX});
      sb_stall      = raw_hazard | waw_hazard | struct_hazard;
   end

   // Stall/flush priority: memory wait, then branch redirect, then decode hazards
   always_comb begin
      stallF_o = 1'b0;
      stallD_o = 1'b0;
      stallE_o = 1'b0;
      stallM_o = 1'b0;
      stallW_o = 1'b0;
      flushD_o = 1'b0;
      flushE_o = 1'b0;
      if (mem_stall) begin
         stallF_o = 1'b1;
         stallD_o = 1'b1;
         stallE_o = 1'b1;
         stallM_o = 1'b1;
         stallW_o = 1'b1;
      end else if (wrong_branch_i) begin
         flushD_o = 1'b1;
         flushE_o = 1'b1;
      end else if (lw_stall | sb_stall) begin
         stallF_o = 1'b1;
         stallD_o = 1'b1;
         flushE_o = 1'b1;
      end
   end

   // Scoreboard update; a set for the same register wins over a same-cycle clear
   always_comb begin
      issue_acc = long_issueE_i & ~stallE_o;
      busy_d    = busy_q & ~done_mask;
      if (issue_acc) begin
         busy_d = busy_d | issue_mask;
      end
      busy_d[0] = 1'b0;
   end

   // Outstanding-op counter: saturating up, ignore completions at zero
   always_comb begin
      done_eff = long_done_i & (count_q != '0);
      count_d  = count_q;
      unique case ({issue_acc, done_eff})
         2'b10: begin
            if (count_q < CNT_MAX) begin
               count_d = count_q + CW'(1);
            end
         end
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Memory-wait watchdog: count stall cycles, pulse once at the limit, then hold
   always_comb begin
      wdog_d = '0;
      tmo_d  = 1'b0;
      err_d  = err_q;
      if (mem_stall) begin
         wdog_d = wdog_q;
         if (wdog_q != WD_LIMIT) begin
            wdog_d = wdog_q + WW'(1);
         end
         if (wdog_q == (WD_LIMIT - WW'(1))) begin
            tmo_d = 1'b1;
            err_d = 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q  <= '0;
         count_q <= '0;
         wdog_q  <= '0;
         tmo_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         wdog_q  <= wdog_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   // Registered status outputs
   always_comb begin
      busy_o        = busy_q;
      outstanding_o = count_q;
      mem_timeout_o = tmo_q;
      err_o         = err_q;
   end

endmodule
